// File: rtl/flags_write_sequencer.sv
// flags_write_sequencer: turns one multi-bit EFLAGS update into a train of
// single-bit flag-register writes. IOPL goes first, then the selected flag bits
// in ascending index order, then a one-cycle done pulse.
module flags_write_sequencer #(
    parameter int unsigned                FLAG_WIDTH    = 18,
    parameter logic [FLAG_WIDTH-1:0]      WRITABLE_MASK = 18'h34FD5
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FLAG_WIDTH-1:0] req_mask,
    input  logic [FLAG_WIDTH-1:0] req_data,
    input  logic                  req_iopl_en,
    input  logic [1:0]            req_iopl_data,
    input  logic                  abort,

    output logic                  write_enable,
    output logic [4:0]            write_index,
    output logic                  write_data,
    output logic                  write_IOPL_enable,
    output logic [1:0]            write_IOPL_data,

    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [FLAG_WIDTH-1:0]   pend_q, pend_d;
    logic [FLAG_WIDTH-1:0]   data_q, data_d;
    logic                    iopl_pend_q, iopl_pend_d;
    logic [1:0]              iopl_data_q, iopl_data_d;

    logic                    accept;
    logic [FLAG_WIDTH-1:0]   req_pend;
    logic [FLAG_WIDTH-1:0]   low_onehot;
    logic [4:0]              low_idx;
    logic                    low_found;

    assign accept   = req_valid & req_ready;
    // Only architecturally writable bits ever become pending.
    assign req_pend = req_mask & WRITABLE_MASK;

    // Isolate the lowest pending bit (two's-complement trick) for clearing.
    assign low_onehot = pend_q & (~pend_q + {{(FLAG_WIDTH-1){1'b0}}, 1'b1});

    // Priority encoder: index of the lowest pending bit.
    always_comb begin
        low_idx   = 5'd0;
        low_found = 1'b0;
        for (int i = 0; i < int'(FLAG_WIDTH); i++) begin
            if (pend_q[i] && !low_found) begin
                low_idx   = 5'(i);
                low_found = 1'b1;
            end
        end
    end

    // State and captured request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pend_q      <= '0;
            data_q      <= '0;
            iopl_pend_q <= 1'b0;
            iopl_data_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            data_q      <= data_d;
            iopl_pend_q <= iopl_pend_d;
            iopl_data_q <= iopl_data_d;
        end
    end

    // Next-state: accept, retire one strobe per ISSUE cycle, abort flush.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        data_d      = data_q;
        iopl_pend_d = iopl_pend_q;
        iopl_data_d = iopl_data_q;

        if (abort) begin
            // Abort outranks a same-cycle accept; the request is simply dropped.
            state_d     = StIdle;
            pend_d      = '0;
            iopl_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        pend_d      = req_pend;
                        data_d      = req_data;
                        iopl_pend_d = req_iopl_en;
                        iopl_data_d = req_iopl_data;
                        state_d     = ((req_pend != '0) || req_iopl_en) ? StIssue : StDone;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StIssue: begin
                    if (iopl_pend_q) begin
                        iopl_pend_d = 1'b0;
                    end else begin
                        pend_d = pend_q & ~low_onehot;
                    end
                    // Leave on the edge that retires the final strobe.
                    if ((pend_d == '0) && !iopl_pend_d) begin
                        state_d = StDone;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    pend_d      = '0;
                    iopl_pend_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        req_ready         = (state_q != StIssue);
        busy              = (state_q == StIssue);
        done              = (state_q == StDone);
        write_enable      = 1'b0;
        write_index       = 5'd0;
        write_data        = 1'b0;
        write_IOPL_enable = 1'b0;
        write_IOPL_data   = 2'b00;
        if (state_q == StIssue) begin
            if (iopl_pend_q) begin
                write_IOPL_enable = 1'b1;
                write_IOPL_data   = iopl_data_q;
            end else if (pend_q != '0) begin
                write_enable = 1'b1;
                write_index  = low_idx;
                write_data   = data_q[low_idx];
            end
        end
    end

    // Sanity: at most one strobe, and bit strobes only hit writable bits.
    a_one_strobe: assert property (@(posedge clock) disable iff (!reset)
        !(write_enable && write_IOPL_enable));
    a_writable: assert property (@(posedge clock) disable iff (!reset)
        write_enable |-> WRITABLE_MASK[write_index]);

endmodule

// File: tb/tb_flags_write_sequencer.sv
// Bench for flags_write_sequencer: table of directed requests, hand-written
// back-to-back / abort / reset sequences, and randomized requests checked
// against a strobe-list model built from the request fields.
module tb_flags_write_sequencer;

    localparam logic [17:0] WM = 18'h34FD5;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [17:0] req_mask;
    logic [17:0] req_data;
    logic        req_iopl_en;
    logic [1:0]  req_iopl_data;
    logic        abort;
    logic        write_enable;
    logic [4:0]  write_index;
    logic        write_data;
    logic        write_IOPL_enable;
    logic [1:0]  write_IOPL_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int obs_strobes;

    typedef struct {
        bit       iopl;
        int       idx;
        bit       d;
        bit [1:0] id;
    } strobe_t;

    strobe_t exp_q[$];

    typedef struct {
        logic [17:0] mask;
        logic [17:0] data;
        logic        ien;
        logic [1:0]  idata;
        int          exp_k;
    } vec_t;

    vec_t vecs[8];

    flags_write_sequencer dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_mask          (req_mask),
        .req_data          (req_data),
        .req_iopl_en       (req_iopl_en),
        .req_iopl_data     (req_iopl_data),
        .abort             (abort),
        .write_enable      (write_enable),
        .write_index       (write_index),
        .write_data        (write_data),
        .write_IOPL_enable (write_IOPL_enable),
        .write_IOPL_data   (write_IOPL_data),
        .busy              (busy),
        .done              (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " req_ready"}, int'(req_ready), 1);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " write_enable"}, int'(write_enable), 0);
        chk({tag, " write_IOPL_enable"}, int'(write_IOPL_enable), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_idle(tag);
        chk({tag, " write_index"}, int'(write_index), 0);
        chk({tag, " write_data"}, int'(write_data), 0);
        chk({tag, " write_IOPL_data"}, int'(write_IOPL_data), 0);
    endtask

    // Model: expected strobe list is IOPL (if requested) then each writable
    // selected bit from low to high.
    task automatic build_model(input logic [17:0] mask, input logic [17:0] data,
                               input logic ien, input logic [1:0] idata);
        strobe_t s;
        exp_q.delete();
        if (ien) begin
            s.iopl = 1'b1; s.idx = 0; s.d = 1'b0; s.id = idata;
            exp_q.push_back(s);
        end
        for (int i = 0; i < 18; i++) begin
            if (mask[i] && WM[i]) begin
                s.iopl = 1'b0; s.idx = i; s.d = data[i]; s.id = 2'b00;
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic check_strobe(input strobe_t s, input string tag);
        chk({tag, " busy"}, int'(busy), 1);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " req_ready"}, int'(req_ready), 0);
        if (s.iopl) begin
            chk({tag, " iopl_en"}, int'(write_IOPL_enable), 1);
            chk({tag, " iopl_data"}, int'(write_IOPL_data), int'(s.id));
            chk({tag, " we_during_iopl"}, int'(write_enable), 0);
        end else begin
            chk({tag, " we"}, int'(write_enable), 1);
            chk({tag, " idx"}, int'(write_index), s.idx);
            chk({tag, " wdata"}, int'(write_data), int'(s.d));
            chk({tag, " iopl_en_during_bit"}, int'(write_IOPL_enable), 0);
        end
    endtask

    // One full request from IDLE; abort_at >= 0 aborts in that strobe cycle.
    task automatic run_req(input logic [17:0] mask, input logic [17:0] data,
                           input logic ien, input logic [1:0] idata, input int abort_at,
                           input string tag);
        int k;
        build_model(mask, data, ien, idata);
        k = exp_q.size();
        obs_strobes = 0;
        req_valid     = 1'b1;
        req_mask      = mask;
        req_data      = data;
        req_iopl_en   = ien;
        req_iopl_data = idata;
        tick();
        req_valid     = 1'b0;
        // Scramble request fields: outputs must come from captured state only.
        req_mask      = 18'($urandom);
        req_data      = 18'($urandom);
        req_iopl_en   = 1'($urandom);
        req_iopl_data = 2'($urandom);
        for (int j = 0; j < k; j++) begin
            check_strobe(exp_q[j], tag);
            if (write_enable || write_IOPL_enable) obs_strobes++;
            if (abort_at == j) abort = 1'b1;
            tick();
            if (abort_at == j) begin
                abort = 1'b0;
                check_idle({tag, " post_abort"});
                tick();
                check_idle({tag, " post_abort2"});
                return;
            end
        end
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " done_busy"}, int'(busy), 0);
        chk({tag, " done_ready"}, int'(req_ready), 1);
        chk({tag, " done_we"}, int'(write_enable), 0);
        chk({tag, " done_iopl"}, int'(write_IOPL_enable), 0);
        tick();
        check_idle({tag, " after_done"});
    endtask

    function automatic int model_k(input logic [17:0] mask, input logic ien);
        int n = 0;
        for (int i = 0; i < 18; i++) if (mask[i] && WM[i]) n++;
        return n + (ien ? 1 : 0);
    endfunction

    initial begin
        logic [17:0] m, d;
        logic        ie;
        logic [1:0]  idt;
        int          k, ab;

        vecs[0] = '{18'h00041, 18'h00001, 1'b0, 2'd0, 2};
        vecs[1] = '{18'h03000, 18'h3FFFF, 1'b0, 2'd0, 0};
        vecs[2] = '{18'h00200, 18'h00200, 1'b1, 2'd3, 2};
        vecs[3] = '{18'h3FFFF, 18'h2AAAA, 1'b0, 2'd0, 12};
        vecs[4] = '{18'h3FFFF, 18'h15555, 1'b1, 2'd1, 13};
        vecs[5] = '{18'h00000, 18'h00000, 1'b1, 2'd2, 1};
        vecs[6] = '{18'h3C000, 18'h3FFFF, 1'b0, 2'd0, 3};
        vecs[7] = '{18'h0A02A, 18'h3FFFF, 1'b0, 2'd0, 0};

        reset = 1'b0;
        req_valid = 1'b0; req_mask = '0; req_data = '0;
        req_iopl_en = 1'b0; req_iopl_data = 2'b00; abort = 1'b0;
        #2;
        check_reset_vals("reset");
        tick();
        reset = 1'b1;
        tick();
        check_reset_vals("post_reset");

        // Directed table.
        foreach (vecs[v]) begin
            run_req(vecs[v].mask, vecs[v].data, vecs[v].ien, vecs[v].idata, -1,
                    $sformatf("vec%0d", v));
            chk($sformatf("vec%0d strobe_count", v), obs_strobes, vecs[v].exp_k);
        end

        // Back-to-back: second request held valid through DONE of the first.
        req_valid = 1'b1; req_mask = 18'h00041; req_data = 18'h00001;
        req_iopl_en = 1'b0; req_iopl_data = 2'b00;
        tick();
        req_valid = 1'b0;
        chk("b2b c1 idx", int'(write_index), 0);
        chk("b2b c1 data", int'(write_data), 1);
        chk("b2b c1 we", int'(write_enable), 1);
        req_valid = 1'b1; req_mask = 18'h00200; req_data = 18'h00200;
        req_iopl_en = 1'b1; req_iopl_data = 2'b11;
        tick();
        chk("b2b c2 idx", int'(write_index), 6);
        chk("b2b c2 data", int'(write_data), 0);
        chk("b2b c2 ready", int'(req_ready), 0);
        tick();
        chk("b2b c3 done", int'(done), 1);
        chk("b2b c3 ready", int'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        chk("b2b next iopl_en", int'(write_IOPL_enable), 1);
        chk("b2b next iopl_data", int'(write_IOPL_data), 3);
        chk("b2b next done", int'(done), 0);
        tick();
        chk("b2b next idx", int'(write_index), 9);
        chk("b2b next data", int'(write_data), 1);
        tick();
        chk("b2b next done", int'(done), 1);
        tick();
        check_idle("b2b end");

        // Abort in the second strobe of an all-ones request.
        run_req(18'h3FFFF, 18'h3FFFF, 1'b0, 2'd0, 1, "abort2nd");
        chk("abort2nd strobe_count", obs_strobes, 2);

        // Abort outranks a same-cycle accept.
        req_valid = 1'b1; req_mask = 18'h3FFFF; req_data = 18'h0; req_iopl_en = 1'b1;
        abort = 1'b1;
        tick();
        req_valid = 1'b0; abort = 1'b0;
        check_idle("abort_vs_accept");
        tick();
        check_idle("abort_vs_accept2");

        // Reset asserted mid-request.
        req_valid = 1'b1; req_mask = 18'h3FFFF; req_data = 18'h3FFFF; req_iopl_en = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_reset pre idx", int'(write_index), 2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("mid_reset async");
        tick();
        check_reset_vals("mid_reset held");
        reset = 1'b1;
        tick();
        check_idle("mid_reset rel1");
        tick();
        check_idle("mid_reset rel2");

        // Randomized requests with occasional aborts and idle gaps.
        for (int r = 0; r < 300; r++) begin
            case ($urandom_range(0, 3))
                0: m = 18'h0;
                1: m = 18'(1) << $urandom_range(0, 17);
                default: m = 18'($urandom);
            endcase
            d   = 18'($urandom);
            ie  = 1'($urandom);
            idt = 2'($urandom);
            k   = model_k(m, ie);
            ab  = (k > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, k - 1)) : -1;
            run_req(m, d, ie, idt, ab, $sformatf("rnd%0d", r));
            if (ab < 0) chk($sformatf("rnd%0d strobe_count", r), obs_strobes, k);
            else        chk($sformatf("rnd%0d strobe_count", r), obs_strobes, ab + 1);
            repeat ($urandom_range(0, 2)) begin
                tick();
                check_idle($sformatf("rnd%0d gap", r));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
